mem_port_arbiter: RTL

Shares the single unified instruction/data memory of the multicycle RISC-V core between two requesters: the core's memory interface (fetch and load/store, address already selected by AdrSrc) and the program loader/debug port. Requests are accepted one at a time with a req/gnt handshake. Each access is sequenced through a small FSM that handles the memory's fixed read latency and returns read data with a one-cycle valid pulse. It sits between the core datapath and the memory model.

---
 rtl/mem_port_arbiter.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - req/gnt arbiter sharing the unified core memory between core and loader
//
// Purpose: accepts one access at a time from either the core memory interface
// (c_*) or the program loader/debug port (l_*), issues it to the memory,
// waits out the fixed read latency and returns read data with a one-cycle
// valid pulse to the requester that owns the access.
//
// Ports:
//   clk_i, reset_ni          clock (rising edge), asynchronous active-low reset
//   c_req_i/c_we_i/c_addr_i/c_wdata_i   core request fields, req held until c_gnt_o
//   c_gnt_o, c_rvalid_o, c_rdata_o      core grant pulse, read-valid pulse, read data
//   l_*                      loader port, same semantics as c_*
//   m_en_o/m_we_o/m_addr_o/m_wdata_o    memory strobe, write enable, address, write data
//   m_rdata_i                memory read data, valid RD_LAT cycles after the m_en cycle
//   busy_o                   high whenever an access is in progress
//
// Parameters: AW address width, DW data width, RD_LAT read latency (1..4).
// Build option: ARB_ROUND_ROBIN_EN - when defined, a tie goes to the requester
// that did not own the previous access; otherwise the core always wins ties.
// All outputs come straight from flops.

module mem_port_arbiter #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic          clk_i,
  input  logic          reset_ni,
  input  logic          c_req_i,
  input  logic          c_we_i,
  input  logic [AW-1:0] c_addr_i,
  input  logic [DW-1:0] c_wdata_i,
  output logic          c_gnt_o,
  output logic          c_rvalid_o,
  output logic [DW-1:0] c_rdata_o,
  input  logic          l_req_i,
  input  logic          l_we_i,
  input  logic [AW-1:0] l_addr_i,
  input  logic [DW-1:0] l_wdata_i,
  output logic          l_gnt_o,
  output logic          l_rvalid_o,
  output logic [DW-1:0] l_rdata_o,
  output logic          m_en_o,
  output logic          m_we_o,
  output logic [AW-1:0] m_addr_o,
  output logic [DW-1:0] m_wdata_o,
  input  logic [DW-1:0] m_rdata_i,
  output logic          busy_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  localparam logic       OWN_CORE = 1'b0;
  localparam logic       OWN_LDR  = 1'b1;
  // WAIT lasts RD_LAT cycles: the counter starts at RD_LAT-1 and the capture
  // happens in the cycle where it reads zero.
  localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

  state_e          state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic            owner_q, owner_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW-1:0]   c_rdata_q, c_rdata_d;
  logic [DW-1:0]   l_rdata_q, l_rdata_d;
  logic            c_gnt_q, c_gnt_d;
  logic            l_gnt_q, l_gnt_d;
  logic            c_rvalid_q, c_rvalid_d;
  logic            l_rvalid_q, l_rvalid_d;
  logic            m_en_q, m_en_d;
  logic            m_we_q, m_we_d;
  logic            busy_q, busy_d;
  logic            pick_ldr;
`ifdef ARB_ROUND_ROBIN_EN
  logic            last_q, last_d;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    owner_d   = owner_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    c_rdata_d = c_rdata_q;
    l_rdata_d = l_rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_d    = last_q;
    // On a tie, hand the memory to whoever did not have it last time.
    pick_ldr  = l_req_i && (!c_req_i || (last_q == OWN_CORE));
`else
    // Fixed priority: the loader only gets in when the core is not asking.
    pick_ldr  = l_req_i && !c_req_i;
`endif

    case (state_q)
      S_IDLE: begin
        if (c_req_i || l_req_i) begin
          owner_d = pick_ldr ? OWN_LDR : OWN_CORE;
          we_d    = pick_ldr ? l_we_i    : c_we_i;
          addr_d  = pick_ldr ? l_addr_i  : c_addr_i;
          wdata_d = pick_ldr ? l_wdata_i : c_wdata_i;
          state_d = S_ISSUE;
`ifdef ARB_ROUND_ROBIN_EN
          last_d  = pick_ldr ? OWN_LDR : OWN_CORE;
`endif
        end
      end
      S_ISSUE: begin
        if (we_q) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 2'd0) begin
          // Only the owner's read-data register is ever touched.
          if (owner_q == OWN_LDR) begin
            l_rdata_d = m_rdata_i;
          end else begin
            c_rdata_d = m_rdata_i;
          end
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Strobes are decoded from the next state so they come out of flops in
    // the same cycle the FSM sits in the corresponding state.
    m_en_d     = (state_d == S_ISSUE);
    m_we_d     = m_en_d && we_d;
    c_gnt_d    = m_en_d && (owner_d == OWN_CORE);
    l_gnt_d    = m_en_d && (owner_d == OWN_LDR);
    c_rvalid_d = (state_d == S_RESP) && (owner_d == OWN_CORE);
    l_rvalid_d = (state_d == S_RESP) && (owner_d == OWN_LDR);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= S_IDLE;
      cnt_q      <= 2'd0;
      owner_q    <= OWN_CORE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      c_rdata_q  <= '0;
      l_rdata_q  <= '0;
      c_gnt_q    <= 1'b0;
      l_gnt_q    <= 1'b0;
      c_rvalid_q <= 1'b0;
      l_rvalid_q <= 1'b0;
      m_en_q     <= 1'b0;
      m_we_q     <= 1'b0;
      busy_q     <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_q     <= OWN_LDR;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      c_rdata_q  <= c_rdata_d;
      l_rdata_q  <= l_rdata_d;
      c_gnt_q    <= c_gnt_d;
      l_gnt_q    <= l_gnt_d;
      c_rvalid_q <= c_rvalid_d;
      l_rvalid_q <= l_rvalid_d;
      m_en_q     <= m_en_d;
      m_we_q     <= m_we_d;
      busy_q     <= busy_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_q     <= last_d;
`endif
    end
  end

  assign c_gnt_o    = c_gnt_q;
  assign l_gnt_o    = l_gnt_q;
  assign c_rvalid_o = c_rvalid_q;
  assign l_rvalid_o = l_rvalid_q;
  assign c_rdata_o  = c_rdata_q;
  assign l_rdata_o  = l_rdata_q;
  assign m_en_o     = m_en_q;
  assign m_we_o     = m_we_q;
  assign m_addr_o   = addr_q;
  assign m_wdata_o  = wdata_q;
  assign busy_o     = busy_q;

endmodule
